// File: rtl/des_decryption_iterative.sv
// Iterative DES core: K16..K1 Feistel rounds, 1/2/4 rounds per clock.
// DES_DECRYPTION_BIDIR_EN adds a latched decrypt input (0 = encrypt).
module des_decryption_iterative #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef DES_DECRYPTION_BIDIR_EN
  input  logic         decrypt,
`endif
  input  logic [1:64]  ciphertext,
  input  logic [1:768] round_keys,
  output logic         busy,
  output logic         done,
  output logic [1:64]  result
);

  localparam int RPC = ROUNDS_PER_CYCLE;
  localparam logic [4:0] CNT_STEP = 5'(RPC);
  localparam logic [4:0] CNT_LAST = 5'(16 - RPC);

  if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [255:0] S1 =
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2 =
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3 =
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4 =
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5 =
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6 =
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7 =
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8 =
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINISH
  } state_t;

  function automatic logic [1:64] ip(input logic [1:64] x);
    return {
      x[58], x[50], x[42], x[34], x[26], x[18], x[10], x[2],
      x[60], x[52], x[44], x[36], x[28], x[20], x[12], x[4],
      x[62], x[54], x[46], x[38], x[30], x[22], x[14], x[6],
      x[64], x[56], x[48], x[40], x[32], x[24], x[16], x[8],
      x[57], x[49], x[41], x[33], x[25], x[17], x[9],  x[1],
      x[59], x[51], x[43], x[35], x[27], x[19], x[11], x[3],
      x[61], x[53], x[45], x[37], x[29], x[21], x[13], x[5],
      x[63], x[55], x[47], x[39], x[31], x[23], x[15], x[7]
    };
  endfunction

  function automatic logic [1:64] fp(input logic [1:64] x);
    return {
      x[40], x[8], x[48], x[16], x[56], x[24], x[64], x[32],
      x[39], x[7], x[47], x[15], x[55], x[23], x[63], x[31],
      x[38], x[6], x[46], x[14], x[54], x[22], x[62], x[30],
      x[37], x[5], x[45], x[13], x[53], x[21], x[61], x[29],
      x[36], x[4], x[44], x[12], x[52], x[20], x[60], x[28],
      x[35], x[3], x[43], x[11], x[51], x[19], x[59], x[27],
      x[34], x[2], x[42], x[10], x[50], x[18], x[58], x[26],
      x[33], x[1], x[41], x[9],  x[49], x[17], x[57], x[25]
    };
  endfunction

  function automatic logic [1:48] e_exp(input logic [1:32] r);
    return {
      r[32], r[1],  r[2],  r[3],  r[4],  r[5],
      r[4],  r[5],  r[6],  r[7],  r[8],  r[9],
      r[8],  r[9],  r[10], r[11], r[12], r[13],
      r[12], r[13], r[14], r[15], r[16], r[17],
      r[16], r[17], r[18], r[19], r[20], r[21],
      r[20], r[21], r[22], r[23], r[24], r[25],
      r[24], r[25], r[26], r[27], r[28], r[29],
      r[28], r[29], r[30], r[31], r[32], r[1]
    };
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] s);
    return {
      s[16], s[7],  s[20], s[21], s[29], s[12], s[28], s[17],
      s[1],  s[15], s[23], s[26], s[5],  s[18], s[31], s[10],
      s[2],  s[8],  s[24], s[14], s[32], s[27], s[3],  s[9],
      s[19], s[13], s[30], s[6],  s[22], s[11], s[4],  s[25]
    };
  endfunction

  // row = outer bits, column = inner four; nibble 0 sits at the top
  function automatic logic [3:0] sbox(
    input logic [255:0] t,
    input logic [5:0]   b
  );
    logic [255:0] sh;
    sh = t << {b[5], b[0], b[4:1], 2'b00};
    return sh[255:252];
  endfunction

  function automatic logic [1:32] feistel(
    input logic [1:32] r,
    input logic [1:48] k
  );
    logic [1:48] x;
    logic [1:32] s;
    x = e_exp(r) ^ k;
    s = {
      sbox(S1, x[1:6]),   sbox(S2, x[7:12]),
      sbox(S3, x[13:18]), sbox(S4, x[19:24]),
      sbox(S5, x[25:30]), sbox(S6, x[31:36]),
      sbox(S7, x[37:42]), sbox(S8, x[43:48])
    };
    return p_perm(s);
  endfunction

  state_t      state;
  state_t      state_nx;
  logic [4:0]  cnt;
  logic [1:32] l_q;
  logic [1:32] r_q;
  logic [1:32] l_nx;
  logic [1:32] r_nx;
  logic        mode_q;
  logic [1:48] keys [16];

  for (genvar n = 0; n < 16; n++) begin : g_key
    assign keys[n] = round_keys[n*48+1 +: 48];
  end

  for (genvar j = 0; j < RPC; j++) begin : g_step
    logic [1:32] l_i;
    logic [1:32] r_i;
    logic [1:32] l_o;
    logic [1:32] r_o;
    logic [3:0]  c;
    logic [3:0]  kidx;
    if (j == 0) begin : g_first
      assign l_i = l_q;
      assign r_i = r_q;
    end else begin : g_next
      assign l_i = g_step[j-1].l_o;
      assign r_i = g_step[j-1].r_o;
    end
    assign c    = cnt[3:0] + 4'(j);
    assign kidx = mode_q ? 4'd15 - c : c;
    assign l_o  = r_i;
    assign r_o  = l_i ^ feistel(r_i, keys[kidx]);
  end

  assign l_nx = g_step[RPC-1].l_o;
  assign r_nx = g_step[RPC-1].r_o;

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ROUND;
      ROUND:   if (cnt == CNT_LAST) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin : outputs
    busy = (state == ROUND);
    done = (state == FINISH);
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      cnt    <= '0;
      l_q    <= '0;
      r_q    <= '0;
      result <= '0;
    end else if (state == IDLE && start) begin
      {l_q, r_q} <= ip(ciphertext);
      cnt        <= '0;
    end else if (state == ROUND) begin
      l_q <= l_nx;
      r_q <= r_nx;
      cnt <= cnt + CNT_STEP;
      // result lands with the last round so it is valid alongside done
      if (cnt == CNT_LAST) result <= fp({r_nx, l_nx});
    end
  end

`ifdef DES_DECRYPTION_BIDIR_EN
  always_ff @(posedge clk) begin : mode_reg
    if (rst)                        mode_q <= 1'b1;
    else if (state == IDLE && start) mode_q <= decrypt;
  end
`else
  assign mode_q = 1'b1;
`endif

endmodule

// File: tb/tb_des_decryption_iterative.sv
// Directed bench for des_decryption_iterative at 1, 2 and 4 rounds/cycle.
// Known DES vectors; round keys built by a bench-side key schedule.
module tb_des_decryption_iterative;

  localparam int RPCS [3] = '{1, 2, 4};
  localparam int LAT  [3] = '{17, 9, 5};

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT2  = 64'h0000000000000000;
  localparam logic [63:0] PT2  = 64'h8787878787878787;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   st;
  logic [1:64]  ct;
  logic [1:768] rk;
  logic         busy_v [3];
  logic         done_v [3];
  logic [1:64]  res_v  [3];
`ifdef DES_DECRYPTION_BIDIR_EN
  logic         dec;
`endif

  int          n_checks = 0;
  int          n_err = 0;
  int          done_at  [3];
  int          ndone    [3];
  int          busy_err [3];
  logic [63:0] res_at   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    des_decryption_iterative #(
      .ROUNDS_PER_CYCLE(RPCS[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (st[g]),
`ifdef DES_DECRYPTION_BIDIR_EN
      .decrypt   (dec),
`endif
      .ciphertext(ct),
      .round_keys(rk),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .result    (res_v[g])
    );
  end

  function automatic logic [1:768] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [47:0]  k;
    logic [1:768] o;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], key[6'(64 - PC1[i])]};
    c = cd[55:28];
    d = cd[27:0];
    o = '0;
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SHIFTS[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      k = '0;
      for (int j = 0; j < 48; j++) k = {k[46:0], cd[6'(56 - PC2[j])]};
      o = {o[49:768], k};
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench in cycle 1 (first cycle after the accept edge)
  task automatic launch(input logic [63:0] c, input logic [63:0] key, input logic [2:0] mask);
    ct = c;
    rk = key_sched(key);
    st = mask;
    cycle();
    st = '0;
    ct = 64'hDEADBEEFF00DCAFE;
  endtask

  task automatic watch(input int ncyc, input int rp_a, input int rp_b);
    for (int d = 0; d < 3; d++) begin
      done_at[d] = -1;
      ndone[d] = 0;
      busy_err[d] = 0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          ndone[d]++;
          done_at[d] = k;
          res_at[d] = res_v[d];
        end
        if (busy_v[d] != (k < LAT[d])) busy_err[d]++;
      end
      st[0] = (k == rp_a) || (k == rp_b);
      cycle();
    end
    st = '0;
  endtask

  initial begin
    int          d1;
    int          d2;
    logic [63:0] r1;
    logic [63:0] r2;
    rst = 1'b1;
    st = '0;
    ct = '0;
    rk = '0;
`ifdef DES_DECRYPTION_BIDIR_EN
    dec = 1'b1;
`endif
    repeat (3) cycle();
    check("reset_busy", 64'(busy_v[0]), 64'd0);
    check("reset_done", 64'(done_v[0]), 64'd0);
    check("reset_result", 64'(res_v[0]), 64'd0);
    rst = 1'b0;
    cycle();

    rk = key_sched(KEY1);
    check("k1_model", 64'(rk[1:48]), 64'h1B02EFFC7072);
    check("k16_model", 64'(rk[721:768]), 64'hCB3D8B0E17F5);

    launch(CT1, KEY1, 3'b111);
    watch(24, 0, 0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("v1_done_cycle_r%0d", RPCS[d]), 64'(done_at[d]), 64'(LAT[d]));
      check($sformatf("v1_done_count_r%0d", RPCS[d]), 64'(ndone[d]), 64'd1);
      check($sformatf("v1_result_r%0d", RPCS[d]), res_at[d], PT1);
      check($sformatf("v1_busy_r%0d", RPCS[d]), 64'(busy_err[d]), 64'd0);
    end
    check("v1_result_held", 64'(res_v[0]), PT1);

    launch(CT1, KEY1, 3'b001);
    watch(24, 3, 10);
    check("repulse_done_count", 64'(ndone[0]), 64'd1);
    check("repulse_done_cycle", 64'(done_at[0]), 64'd17);
    check("repulse_result", res_at[0], PT1);

    launch(CT2, KEY2, 3'b001);
    d1 = -1;
    d2 = -1;
    r1 = '0;
    r2 = '0;
    for (int k = 1; k <= 45; k++) begin
      if (done_v[0]) begin
        if (d1 < 0) begin
          d1 = k;
          r1 = res_v[0];
        end else begin
          d2 = k;
          r2 = res_v[0];
        end
      end
      st[0] = (d1 > 0) && (k == d1 + 1);
      if (st[0]) begin
        ct = CT1;
        rk = key_sched(KEY1);
      end
      cycle();
    end
    st = '0;
    check("b2b_first_cycle", 64'(d1), 64'd17);
    check("b2b_first_result", r1, PT2);
    check("b2b_gap", 64'(d2 - d1), 64'd18);
    check("b2b_second_result", r2, PT1);

    launch(CT1, KEY1, 3'b001);
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", 64'(busy_v[0]), 64'd0);
    check("midrst_done", 64'(done_v[0]), 64'd0);
    check("midrst_result", 64'(res_v[0]), 64'd0);
    watch(20, 0, 0);
    check("midrst_no_done", 64'(ndone[0]), 64'd0);
    launch(CT1, KEY1, 3'b001);
    watch(24, 0, 0);
    check("after_rst_cycle", 64'(done_at[0]), 64'd17);
    check("after_rst_result", res_at[0], PT1);

`ifdef DES_DECRYPTION_BIDIR_EN
    dec = 1'b0;
    ct = PT1;
    rk = key_sched(KEY1);
    st = 3'b111;
    cycle();
    st = '0;
    dec = 1'b1;
    watch(24, 0, 0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("enc_cycle_r%0d", RPCS[d]), 64'(done_at[d]), 64'(LAT[d]));
      check($sformatf("enc_result_r%0d", RPCS[d]), res_at[d], CT1);
    end
    launch(res_at[0], KEY1, 3'b001);
    watch(24, 0, 0);
    check("enc_dec_roundtrip", res_at[0], PT1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
